// File: rtl/pw_conv_stage.sv
// Pointwise (1x1) convolution stage: 9 signed channels times serially loaded weights plus bias,
// rescaled and saturated, 3-cycle pipeline. Optional macro PW_RELU_EN clamps negative results to 0.
module pw_conv_stage #(
    parameter int int_bits  = 13,
    parameter int frac_bits = 6
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       latency_in,
    input  logic signed [int_bits-1:0] in [9],
    input  logic                       weight_en,
    input  logic signed [int_bits-1:0] weight_in,
    output logic signed [int_bits-1:0] out,
    output logic                       latency_out,
    output logic                       w_ready
);
    localparam int PW = 2 * int_bits;
    localparam int SW = 2 * int_bits + 2;
    localparam int AW = 2 * int_bits + 4;
    localparam logic signed [int_bits-1:0] OUT_MAX = {1'b0, {(int_bits-1){1'b1}}};
    localparam logic signed [int_bits-1:0] OUT_MIN = {1'b1, {(int_bits-1){1'b0}}};

    // coef_reg[9] is the bias, coef_reg[8-i] is the weight for in[i]
    logic signed [int_bits-1:0] coef_reg [10];
    logic [3:0]                 load_cnt_reg;
    logic                       accept;

    logic                       v1_reg;
    logic                       v2_reg;
    logic signed [PW-1:0]       prod_reg [9];
    logic signed [int_bits-1:0] bias1_reg;
    logic signed [int_bits-1:0] bias2_reg;
    logic signed [SW-1:0]       psum_reg [3];

    logic signed [AW-1:0]       acc_sum;
    logic signed [AW-1:0]       acc_shift;
    logic signed [int_bits-1:0] sat_val;
    logic signed [int_bits-1:0] res_val;

    assign w_ready = (load_cnt_reg == 4'd10);
    assign accept  = latency_in & w_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < 10; k++) coef_reg[k] <= '0;
            load_cnt_reg <= '0;
        end else if (weight_en) begin
            coef_reg[0] <= weight_in;
            for (int k = 1; k < 10; k++) coef_reg[k] <= coef_reg[k-1];
            if (load_cnt_reg != 4'd10) load_cnt_reg <= load_cnt_reg + 4'd1;
        end
    end

    // P1: products; the bias travels with the sample so a later reload cannot mix sets
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v1_reg    <= 1'b0;
            bias1_reg <= '0;
            for (int k = 0; k < 9; k++) prod_reg[k] <= '0;
        end else begin
            v1_reg <= accept;
            if (accept) begin
                for (int k = 0; k < 9; k++)
                    prod_reg[k] <= PW'(in[k]) * PW'(coef_reg[8-k]);
                bias1_reg <= coef_reg[9];
            end
        end
    end

    // P2: three partial sums of three products each
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v2_reg    <= 1'b0;
            bias2_reg <= '0;
            for (int j = 0; j < 3; j++) psum_reg[j] <= '0;
        end else begin
            v2_reg <= v1_reg;
            if (v1_reg) begin
                for (int j = 0; j < 3; j++)
                    psum_reg[j] <= SW'(prod_reg[3*j]) + SW'(prod_reg[3*j+1]) + SW'(prod_reg[3*j+2]);
                bias2_reg <= bias1_reg;
            end
        end
    end

    always_comb begin
        acc_sum   = AW'(psum_reg[0]) + AW'(psum_reg[1]) + AW'(psum_reg[2])
                  + (AW'(bias2_reg) <<< frac_bits);
        acc_shift = acc_sum >>> frac_bits;
        sat_val   = acc_shift[int_bits-1:0];
        if (acc_shift > AW'(OUT_MAX))
            sat_val = OUT_MAX;
        else if (acc_shift < AW'(OUT_MIN))
            sat_val = OUT_MIN;
`ifdef PW_RELU_EN
        res_val = sat_val[int_bits-1] ? '0 : sat_val;
`else
        res_val = sat_val;
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out         <= '0;
            latency_out <= 1'b0;
        end else begin
            latency_out <= v2_reg;
            if (v2_reg) out <= res_val;
        end
    end
endmodule

// File: tb/tb_pw_conv_stage.sv
// Directed testbench for pw_conv_stage (int_bits=13, frac_bits=6), hand-computed expectations.
module tb_pw_conv_stage;
    logic               clk;
    logic               reset;
    logic               latency_in;
    logic signed [12:0] in_vec [9];
    logic               weight_en;
    logic signed [12:0] weight_in;
    logic signed [12:0] out;
    logic               latency_out;
    logic               w_ready;

    int n_tests = 0;
    int n_fail  = 0;
    int lat_cnt = 0;
    int saved_cnt;

    pw_conv_stage #(.int_bits(13), .frac_bits(6)) dut (
        .clk(clk), .reset(reset), .latency_in(latency_in), .in(in_vec),
        .weight_en(weight_en), .weight_in(weight_in),
        .out(out), .latency_out(latency_out), .w_ready(w_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (latency_out) lat_cnt++;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            $display("[TB] ok   %s: %0d", tag, got);
        end
    endtask

    // bias first, then weight for in[0] (w0), then in[1..8] (wrest)
    task automatic load_set(input int bias, input int w0, input int wrest, input bit fresh);
        for (int i = 0; i < 10; i++) begin
            weight_in = (i == 0) ? 13'(bias) : ((i == 1) ? 13'(w0) : 13'(wrest));
            weight_en = 1'b1;
            @(negedge clk);
            if (fresh && i == 8) check("w_ready_after_9", int'(w_ready), 0);
        end
        weight_en = 1'b0;
        check("w_ready_after_10", int'(w_ready), 1);
    endtask

    task automatic set_vec(input int v0, input int vrest);
        in_vec[0] = 13'(v0);
        for (int i = 1; i < 9; i++) in_vec[i] = 13'(vrest);
    endtask

    // one pulse, then require latency_out exactly on the third cycle and only for one cycle
    task automatic run_one(input string tag, input int exp);
        latency_in = 1'b1;
        @(negedge clk);
        latency_in = 1'b0;
        check({tag, "_lat1"}, int'(latency_out), 0);
        @(negedge clk);
        check({tag, "_lat2"}, int'(latency_out), 0);
        @(negedge clk);
        check({tag, "_lat3"}, int'(latency_out), 1);
        check({tag, "_out"}, int'(out), exp);
        @(negedge clk);
        check({tag, "_lat4"}, int'(latency_out), 0);
    endtask

    initial begin
        reset = 1'b0; latency_in = 1'b0; weight_en = 1'b0; weight_in = '0;
        set_vec(0, 0);
        @(negedge clk);
        check("rst_out", int'(out), 0);
        check("rst_lat", int'(latency_out), 0);
        check("rst_wready", int'(w_ready), 0);
        reset = 1'b1;
        @(negedge clk);

        // unity weights, zero bias: sum of 1..9
        load_set(0, 64, 64, 1'b1);
        for (int i = 0; i < 9; i++) in_vec[i] = 13'(i + 1);
        run_one("sum45", 45);
        set_vec(4095, 4095);
        run_one("sat_pos", 4095);
        set_vec(-4096, -4096);
`ifdef PW_RELU_EN
        run_one("sat_neg", 0);
`else
        run_one("sat_neg", -4096);
`endif

        // bias 128 enters as (128<<6), w0 = 0.5: floor((-96+8192)/64)=126, floor((224+8192)/64)=131
        load_set(128, 32, 0, 1'b0);
        set_vec(-3, 0);
        run_one("bias_neg_in", 126);
        set_vec(7, 0);
        run_one("bias_pos_in", 131);
        // bias -2: floor((-96-128)/64) = floor(-3.5) = -4
        load_set(-2, 32, 0, 1'b0);
        set_vec(-3, 0);
`ifdef PW_RELU_EN
        run_one("floor_neg", 0);
`else
        run_one("floor_neg", -4);
`endif

        // inputs before w_ready are dropped
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        saved_cnt = lat_cnt;
        set_vec(3, 3);
        for (int i = 0; i < 4; i++) begin
            latency_in = 1'b1;
            @(negedge clk);
            latency_in = 1'b0;
            @(negedge clk);
        end
        repeat (4) @(negedge clk);
        check("drop_no_out", lat_cnt - saved_cnt, 0);

        // five back-to-back vectors, outputs 10..14 back-to-back
        load_set(0, 64, 0, 1'b1);
        for (int cyc = 0; cyc < 9; cyc++) begin
            if (cyc >= 3 && cyc < 8) begin
                check($sformatf("b2b_lat%0d", cyc), int'(latency_out), 1);
                check($sformatf("b2b_out%0d", cyc), int'(out), 10 + cyc - 3);
            end else begin
                check($sformatf("b2b_lat%0d", cyc), int'(latency_out), 0);
            end
            if (cyc < 5) begin
                set_vec(10 + cyc, 0);
                latency_in = 1'b1;
            end else begin
                latency_in = 1'b0;
            end
            @(negedge clk);
        end

        // same-edge load: first vector uses old set (9), second uses shifted set (8*1 + bias 64)
        load_set(0, 64, 64, 1'b0);
        set_vec(1, 1);
        latency_in = 1'b1; weight_en = 1'b1; weight_in = '0;
        @(negedge clk);
        weight_en = 1'b0;
        @(negedge clk);
        latency_in = 1'b0;
        @(negedge clk);
        check("same_edge_old", int'(out), 9);
        check("same_edge_old_lat", int'(latency_out), 1);
        @(negedge clk);
        check("same_edge_new", int'(out), 72);
        check("same_edge_new_lat", int'(latency_out), 1);

        // reset with two samples in flight
        load_set(0, 64, 64, 1'b0);
        set_vec(5, 0);
        latency_in = 1'b1;
        @(negedge clk);
        @(negedge clk);
        latency_in = 1'b0;
        saved_cnt = lat_cnt;
        #1 reset = 1'b0;
        #1;
        check("midrst_out", int'(out), 0);
        check("midrst_lat", int'(latency_out), 0);
        check("midrst_wready", int'(w_ready), 0);
        @(negedge clk);
        reset = 1'b1;
        repeat (5) @(negedge clk);
        check("midrst_no_pulse", lat_cnt - saved_cnt, 0);
        load_set(0, 64, 64, 1'b1);
        set_vec(2, 2);
        run_one("after_rst", 18);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
